// File: rtl/latch_pkg.sv
// Shared types and defaults for the latch output capture block.
package latch_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        FILTER = 1'b1
    } filt_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CNT_DEF  = 4;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= d;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_reg[gi] <= 1'b0;
            end else begin
                sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/latch_capture.sv
// Synchronizes and debounces an upstream latch level, then reports each
// accepted edge as a single-entry ready/valid event with a sticky overrun flag.
module latch_capture
    import latch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CNT  = STABLE_CNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic q_in,
    input  logic evt_ready,
    input  logic clear_ovr,
    output logic q_filt,
    output logic evt_valid,
    output logic evt_rise,
    output logic overrun
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t CNT_MAX = cnt_t'(STABLE_CNT);

    logic        s_q;
    filt_state_t state_reg, state_next;
    cnt_t        cnt_reg, cnt_next;
    logic        q_filt_reg, q_filt_next;
    logic        evt_valid_reg, evt_valid_next;
    logic        evt_rise_reg, evt_rise_next;
    logic        overrun_reg, overrun_next;
    logic        evt_gen;
    logic        evt_drop;
    logic        evt_fire;
    logic        differ;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_in),
        .q     (s_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            q_filt_reg    <= 1'b0;
            evt_valid_reg <= 1'b0;
            evt_rise_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            q_filt_reg    <= q_filt_next;
            evt_valid_reg <= evt_valid_next;
            evt_rise_reg  <= evt_rise_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        q_filt_next = q_filt_reg;
        evt_gen     = 1'b0;
        differ      = (s_q != q_filt_reg);

        case (state_reg)
            IDLE: begin
                if (differ) begin
                    state_next = FILTER;
                    cnt_next   = CNT_ONE;
                end
            end
            FILTER: begin
                if (!differ) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Acceptance happens on the edge the count would reach STABLE_CNT,
        // so the counter itself never has to hold that value.
        if (differ && (cnt_next == CNT_MAX)) begin
            state_next  = IDLE;
            cnt_next    = '0;
            q_filt_next = s_q;
            evt_gen     = 1'b1;
        end
    end

    always_comb begin
        evt_fire       = evt_valid_reg && evt_ready;
        evt_drop       = evt_gen && evt_valid_reg && !evt_ready;
        evt_valid_next = evt_gen || (evt_valid_reg && !evt_fire);
        evt_rise_next  = (evt_gen && !evt_drop) ? s_q : evt_rise_reg;
        if (evt_drop) begin
            overrun_next = 1'b1;
        end else if (clear_ovr) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = overrun_reg;
        end
    end

    assign q_filt    = q_filt_reg;
    assign evt_valid = evt_valid_reg;
    assign evt_rise  = evt_rise_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_latch_capture.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a window-based model.
module tb_latch_capture;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic q_in      = 1'b0;
    logic evt_ready = 1'b0;
    logic clear_ovr = 1'b0;
    logic q_filt;
    logic evt_valid;
    logic evt_rise;
    logic overrun;

    always #5 clk = ~clk;

    latch_capture #(
        .SYNC_STAGES (SS),
        .STABLE_CNT  (SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q_in      (q_in),
        .evt_ready (evt_ready),
        .clear_ovr (clear_ovr),
        .q_filt    (q_filt),
        .evt_valid (evt_valid),
        .evt_rise  (evt_rise),
        .overrun   (overrun)
    );

    // Model: delay line for the synchronizer, and a window of the last SC
    // synchronized samples; a full window that all disagree with q_filt flips it.
    bit m_sync [SS];
    bit win [$];
    bit m_filt, m_valid, m_rise, m_ovr;

    int chk_cnt    = 0;
    int pass_cnt   = 0;
    bit seen_valid = 1'b0;
    int cyc_no     = 0;

    task automatic check(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_step(input bit q, input bit rdy, input bit clr, input bit rstn);
        bit s_pre, gen, drop, fire;
        if (!rstn) begin
            for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
            win.delete();
            m_filt  = 1'b0;
            m_valid = 1'b0;
            m_rise  = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        s_pre = m_sync[SS-1];
        for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = q;
        win.push_back(s_pre != m_filt);
        if (win.size() > SC) void'(win.pop_front());
        gen = (win.size() == SC);
        foreach (win[i]) if (!win[i]) gen = 1'b0;
        if (gen) begin
            m_filt = s_pre;
            win.delete();
        end
        fire = m_valid && rdy;
        drop = gen && m_valid && !rdy;
        if (gen && !drop) begin
            m_valid = 1'b1;
            m_rise  = s_pre;
        end else if (fire) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit q, input bit rdy, input bit clr, input bit rstn);
        q_in      = q;
        evt_ready = rdy;
        clear_ovr = clr;
        rst_n     = rstn;
        model_step(q, rdy, clr, rstn);
        @(posedge clk);
        #1;
        cyc_no++;
        if (evt_valid === 1'b1) seen_valid = 1'b1;
        check("q_filt", q_filt, m_filt);
        check("evt_valid", evt_valid, m_valid);
        if (m_valid) check("evt_rise", evt_rise, m_rise);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic do_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int hold;
        bit qv;

        // Reset state
        do_reset();
        check("rst_q_filt", q_filt, 1'b0);
        check("rst_evt_valid", evt_valid, 1'b0);
        check("rst_evt_rise", evt_rise, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        // Rising edge: accepted at edge SS+SC, consumed one cycle later
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            if (k == 5) begin
                check("rise_e5_q_filt", q_filt, 1'b0);
                check("rise_e5_valid", evt_valid, 1'b0);
            end
            if (k == 6) begin
                check("rise_e6_q_filt", q_filt, 1'b1);
                check("rise_e6_valid", evt_valid, 1'b1);
                check("rise_e6_rise", evt_rise, 1'b1);
            end
            if (k == 7) begin
                check("rise_e7_valid", evt_valid, 1'b0);
                check("rise_e7_q_filt", q_filt, 1'b1);
            end
        end

        // Short pulse rejected
        do_reset();
        seen_valid = 1'b0;
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("glitch_no_event", seen_valid, 1'b0);
        check("glitch_q_filt", q_filt, 1'b0);

        // Stalled consumer: fall dropped, oldest event kept, then cleared
        do_reset();
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_valid", evt_valid, 1'b1);
        check("ovr_rise_kept", evt_rise, 1'b1);
        check("ovr_set", overrun, 1'b1);
        check("ovr_q_filt", q_filt, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr_cleared", overrun, 1'b0);
        check("ovr_clr_rise", evt_rise, 1'b1);
        check("ovr_clr_valid", evt_valid, 1'b1);

        // Fall matures on the same edge the pending rise is accepted
        do_reset();
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("swap_valid", evt_valid, 1'b1);
        check("swap_rise", evt_rise, 1'b0);
        check("swap_overrun", overrun, 1'b0);
        check("swap_q_filt", q_filt, 1'b0);

        // Reset mid-filter discards the partial count
        do_reset();
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_q_filt", q_filt, 1'b0);
        check("midrst_valid", evt_valid, 1'b0);
        seen_valid = 1'b0;
        repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst_no_event", seen_valid, 1'b0);
        check("midrst_q_filt_after", q_filt, 1'b0);

        // Randomized traffic against the model
        do_reset();
        hold = 0;
        qv   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                qv   = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 9));
            end
            hold--;
            cyc(qv, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 199) != 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
